// File: rtl/div_unit.sv
// div_unit: iterative RV32M divider (DIV/DIVU/REM/REMU), radix-2 restoring,
// one quotient bit per cycle, with a write-back request toward the register file.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. Issue side: in_valid/in_ready, where in_ready is high only in IDLE.
// Write-back side: wb_valid/wb_ready, where wb_valid holds with stable
// wb_rd/wb_data until accepted. flush blocks an issue in the same cycle, but it
// does not cancel a write-back handshake that completes on the same edge.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic [4:0]       rd,
  input  logic             flush,
  output logic             busy,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [4:0]       wb_rd,
  output logic [WIDTH-1:0] wb_data,
  output logic             wb_we
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic             is_rem_q;   // 1: REM/REMU result, 0: DIV/DIVU result
  logic [4:0]       rd_q;
  logic [WIDTH-1:0] quo;        // dividend magnitude shifts out, quotient shifts in
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvs;        // divisor magnitude
  logic [WIDTH-1:0] res;
  logic             qneg;
  logic             rneg;
  logic             special;    // div-by-zero / overflow: result already in res
  logic [CW-1:0]    cnt;

  // Issue-side decode of the operands presented in IDLE.
  logic             accept;
  logic             is_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             div_zero;
  logic             overflow;

  assign accept    = in_valid && in_ready && !flush;
  assign is_signed = !op[0];
  assign a_neg     = is_signed && rs1_data[WIDTH-1];
  assign b_neg     = is_signed && rs2_data[WIDTH-1];
  assign a_mag     = a_neg ? -rs1_data : rs1_data;
  assign b_mag     = b_neg ? -rs2_data : rs2_data;
  assign div_zero  = (rs2_data == '0);
  assign overflow  = is_signed && (rs1_data == {1'b1, {(WIDTH-1){1'b0}}}) && (rs2_data == '1);

  // One restoring step. The shifted remainder is kept WIDTH+1 bits wide so that
  // unsigned divisors with the top bit set compare correctly; the borrow of the
  // trial subtraction decides the quotient bit.
  logic [WIDTH:0]   rem_ext;
  logic [WIDTH:0]   rem_sub;
  logic             ge;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic             last;

  assign rem_ext  = {rem, quo[WIDTH-1]};
  assign rem_sub  = rem_ext - {1'b0, dvs};
  assign ge       = !rem_sub[WIDTH];
  assign rem_step = ge ? rem_sub[WIDTH-1:0] : rem_ext[WIDTH-1:0];
  assign quo_step = {quo[WIDTH-2:0], ge};
  assign quo_fix  = qneg ? -quo_step : quo_step;
  assign rem_fix  = rneg ? -rem_step : rem_step;
  assign last     = (cnt == CW'(1));

  // State register; reset has priority.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; flush returns to IDLE from any state.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = CALC;
      CALC: if (special || last) state_next = DONE;
      DONE: if (wb_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // Operand capture at issue and the iteration datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_rem_q <= 1'b0;
      rd_q     <= '0;
      quo      <= '0;
      rem      <= '0;
      dvs      <= '0;
      res      <= '0;
      qneg     <= 1'b0;
      rneg     <= 1'b0;
      special  <= 1'b0;
      cnt      <= '0;
    end else if (accept) begin
      is_rem_q <= op[1];
      rd_q     <= rd;
      quo      <= a_mag;
      rem      <= '0;
      dvs      <= b_mag;
      qneg     <= a_neg ^ b_neg;
      rneg     <= a_neg;
      special  <= div_zero || overflow;
      cnt      <= CW'(WIDTH);
      if (div_zero)      res <= op[1] ? rs1_data : '1;
      else if (overflow) res <= op[1] ? '0 : rs1_data;
    end else if (state == CALC && !special && !flush) begin
      quo <= quo_step;
      rem <= rem_step;
      cnt <= cnt - CW'(1);
      if (last) res <= is_rem_q ? rem_fix : quo_fix;
    end
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state == CALC) || (state == DONE);
  assign wb_valid = (state == DONE);
  assign wb_rd    = rd_q;
  assign wb_data  = res;
  assign wb_we    = wb_valid && (wb_rd != 5'd0);

endmodule
